serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. Time-shares one 1-bit `fulladder` cell to add two WIDTH-bit operands, one bit per clock, LSB first, with a registered carry between bits. Uses a start/done handshake and holds the result until the next accepted start. Intended as the sequencing front end for the lab's full-adder datapath, in place of a WIDTH-wide ripple adder.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when ready=1.
a_in  input  WIDTH  operand A; captured on the accepted start.
b_in  input  WIDTH  operand B; captured on the accepted start.
cin_in  input  1  carry-in; captured on the accepted start.
ready  output  1  high in IDLE only.
busy  output  1  high in ADD only.
done  output  1  one-cycle pulse in DONE.
sum  output  WIDTH  registered result; held until the next accepted start.
cout  output  1  carry out of the MSB.
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Interface rule: one clock (clk); reset (rst) is synchronous and active-high. No asynchronous logic.
- Reset: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0; counter, operand shift registers and carry register cleared.
- Reset mid-operation: aborts immediately. Partial results are discarded and all outputs take their reset values on that edge.
- FSM states: IDLE, ADD, DONE. Encodings come from the shared header.
- IDLE: when start=1 at an edge:
  - load a_sh<=a_in, b_sh<=b_in, c_reg<=cin_in, cnt<=0;
  - clear the result shift register;
  - go to ADD.
  - sum, cout and ovf keep their previous values until the new result commits.
- ADD: the full adder is driven by x=a_sh[0], y=b_sh[0], cin=c_reg. Each edge:
  - shift a_sh and b_sh right by 1;
  - shift the adder's sum bit into the MSB of the result register (right-shift fill);
  - c_reg<=cout of the adder;
  - cnt<=cnt+1.
- On the edge where cnt==WIDTH-1:
  - capture c_reg, i.e. the carry into the MSB, into ovf-compute;
  - commit sum<=final result register, cout<=adder cout, ovf<=c_reg XOR adder cout;
  - go to DONE.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE unconditionally.
- Latency: start sampled at edge k. busy is high for cycles k..k+WIDTH-1; done is high in the cycle after edge k+WIDTH. The new sum is valid from that same cycle.
- start while busy or done: ignored, not queued. Operand inputs are don't-care outside the accept edge.
- start held continuously high: accepted again at the first edge in IDLE, giving a throughput of one add per WIDTH+2 cycles.
- Arithmetic: unsigned sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the full sum. Counter wrap cannot occur because cnt resets on each accept.
- Exactly one of ready/busy/done is high in every cycle.

Decomposition:
- Shared header `serial_adder_defs.vh`:
  - state encodings S_IDLE=2'd0, S_ADD=2'd1, S_DONE=2'd2;
  - default WIDTH constant.
- One sub-module: the existing `fulladder` (ports x, y, cin, A, cout), instantiated once as the bit-slice datapath.
- The FSM, counter and shift registers stay inline in serial_adder_ctrl.

Test Plan:
1. WIDTH=8, rst for 2 cycles, then a=0x0F, b=0x01, cin=0, start pulse -> done exactly 8 cycles after the accept edge, sum=0x10, cout=0, ovf=0; ready back to 1 next cycle.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
3. a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
4. Pulse start with new operands (0x11+0x22) during busy cycle 3 -> ignored. Current result completes unchanged, no second done, ready stays 0 until after done.
5. Assert rst at ADD cycle 4 of 0xAA+0x55 -> next cycle ready=1, busy=0, done=0, sum=0, cout=0, ovf=0. A subsequent start of 0xAA+0x55 -> sum=0xFF, cout=0.
6. Hold start=1 across two back-to-back ops (0x01+0x02, then 0x03+0x04) -> two done pulses 10 cycles apart, sum=0x03 then 0x07. The first sum holds 0x03 until the second result commits.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and default sizes.
package serial_adder_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultCntW  = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder; the single datapath slice time-shared by the serial adder controller.
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic A,
  output logic cout
);

  assign A    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first through one full-adder cell,
// with a start/ready handshake and a result held until the next accepted start.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               fa_s;
  logic               fa_cout;

  fulladder u_fulladder (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (c_q),
    .A    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = cin_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {fa_s, res_q[WIDTH-1:1]};
        c_d   = fa_cout;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // c_q here is the carry into the MSB, so it feeds the overflow term.
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = c_q ^ fa_cout;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q == StAdd);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule
